// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipeline control carrier.
package ctrl_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Decoder ALU classes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    // Per-instruction control bits carried down the pipe (register numbers travel alongside)
    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register; MEM result wins over WB.
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_wreg,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_wreg,
    output logic [1:0]       sel_c
);

    // Pick the youngest in-flight producer of src; $zero is never forwarded
    always_comb begin
        sel_c = FWD_RF;
        if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == src)) begin
            sel_c = FWD_MEM;
        end else if (wb_reg_write && (wb_wreg != '0) && (wb_wreg == src)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Carries decoder control through EX/MEM/WB, detects stall/flush, and drives forwarding selects.
module pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             RegDst_i,
    input  logic             ALUSrc_i,
    input  logic             MemtoReg_i,
    input  logic             RegWrite_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             Branch_i,
    input  logic             Jump_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             br_eq_i,
    output logic             ex_ALUSrc_o,
    output logic [1:0]       ex_ALUOp_o,
    output logic             mem_MemRead_o,
    output logic             mem_MemWrite_o,
    output logic             wb_RegWrite_o,
    output logic             wb_MemtoReg_o,
    output logic [REG_W-1:0] wb_wreg_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic             flush_o
);

    ctrl_bundle_t     id_ctrl;
    logic [REG_W-1:0] id_wreg;

    ctrl_bundle_t     ex_ctrl;
    logic [REG_W-1:0] ex_rs, ex_rt, ex_wreg;

    logic             mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write;
    logic [REG_W-1:0] mem_wreg;

    logic             wb_reg_write, wb_mem_to_reg;
    logic [REG_W-1:0] wb_wreg;

    logic             load_use, br_hazard, ex_hits_id, mem_hits_id;

    // Normalise the ID bundle so non-writing instructions carry no destination
    always_comb begin
        id_ctrl            = CTRL_BUBBLE;
        id_ctrl.alu_src    = ALUSrc_i;
        id_ctrl.alu_op     = ALUOp_i;
        id_ctrl.reg_write  = RegWrite_i;
        id_ctrl.mem_to_reg = RegWrite_i & MemtoReg_i;
        id_ctrl.mem_read   = MemRead_i;
        id_ctrl.mem_write  = MemWrite_i;
        id_wreg            = '0;
        if (RegWrite_i) begin
            id_wreg = RegDst_i ? rd_i : rt_i;
        end
    end

    // Hazard detection and redirect, evaluated against the instruction currently in ID
    always_comb begin
        ex_hits_id  = (ex_wreg != '0) && ((ex_wreg == rs_i) || (ex_wreg == rt_i));
        mem_hits_id = (mem_wreg != '0) && ((mem_wreg == rs_i) || (mem_wreg == rt_i));
        load_use    = ex_ctrl.mem_read & ex_hits_id;
        br_hazard   = Branch_i & ((ex_ctrl.reg_write & ex_hits_id) | (mem_mem_read & mem_hits_id));
        stall_o     = load_use | br_hazard;
        flush_o     = ~stall_o & (Jump_i | (Branch_i & br_eq_i));
    end

    // Shift ID->EX->MEM->WB; a stall injects a bubble into EX while older stages drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl        <= CTRL_BUBBLE;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_wreg        <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_wreg       <= '0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_wreg        <= '0;
        end else begin
            if (stall_o) begin
                ex_ctrl <= CTRL_BUBBLE;
                ex_rs   <= '0;
                ex_rt   <= '0;
                ex_wreg <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rs   <= rs_i;
                ex_rt   <= rt_i;
                ex_wreg <= id_wreg;
            end
            mem_reg_write  <= ex_ctrl.reg_write;
            mem_mem_to_reg <= ex_ctrl.mem_to_reg;
            mem_mem_read   <= ex_ctrl.mem_read;
            mem_mem_write  <= ex_ctrl.mem_write;
            mem_wreg       <= ex_wreg;
            wb_reg_write   <= mem_reg_write;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_wreg        <= mem_wreg;
        end
    end

    assign ex_ALUSrc_o    = ex_ctrl.alu_src;
    assign ex_ALUOp_o     = ex_ctrl.alu_op;
    assign mem_MemRead_o  = mem_mem_read;
    assign mem_MemWrite_o = mem_mem_write;
    assign wb_RegWrite_o  = wb_reg_write;
    assign wb_MemtoReg_o  = wb_mem_to_reg;
    assign wb_wreg_o      = wb_wreg;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src           (ex_rs),
        .mem_reg_write (mem_reg_write),
        .mem_wreg      (mem_wreg),
        .wb_reg_write  (wb_reg_write),
        .wb_wreg       (wb_wreg),
        .sel_c         (fwd_a_o)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src           (ex_rt),
        .mem_reg_write (mem_reg_write),
        .mem_wreg      (mem_wreg),
        .wb_reg_write  (wb_reg_write),
        .wb_wreg       (wb_wreg),
        .sel_c         (fwd_b_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, forwarding, redirect, latency and reset.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
    logic [1:0] alu_op;
    logic [4:0] rs, rt, rd;
    logic       br_eq;

    logic       ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       mem_mem_read, mem_mem_write;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_wreg;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, flush;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_ctrl #(.REG_W(5)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .RegDst_i       (reg_dst),
        .ALUSrc_i       (alu_src),
        .MemtoReg_i     (mem_to_reg),
        .RegWrite_i     (reg_write),
        .MemRead_i      (mem_read),
        .MemWrite_i     (mem_write),
        .Branch_i       (branch),
        .Jump_i         (jump),
        .ALUOp_i        (alu_op),
        .rs_i           (rs),
        .rt_i           (rt),
        .rd_i           (rd),
        .br_eq_i        (br_eq),
        .ex_ALUSrc_o    (ex_alu_src),
        .ex_ALUOp_o     (ex_alu_op),
        .mem_MemRead_o  (mem_mem_read),
        .mem_MemWrite_o (mem_mem_write),
        .wb_RegWrite_o  (wb_reg_write),
        .wb_MemtoReg_o  (wb_mem_to_reg),
        .wb_wreg_o      (wb_wreg),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .stall_o        (stall),
        .flush_o        (flush)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs and checks happen 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic rw, input logic dst, input logic asrc, input logic m2r,
                          input logic mr, input logic mw, input logic br, input logic jp,
                          input logic [1:0] op, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic eq);
        reg_write = rw; reg_dst = dst; alu_src = asrc; mem_to_reg = m2r;
        mem_read = mr; mem_write = mw; branch = br; jump = jp;
        alu_op = op; rs = s; rt = t; rd = d; br_eq = eq;
        #1;
    endtask

    task automatic id_nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic id_rtype(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, s, t, d, 0);
    endtask

    task automatic id_lw(input logic [4:0] t, input logic [4:0] base);
        set_id(1, 0, 1, 1, 1, 0, 0, 0, 2'b00, base, t, 5'd0, 0);
    endtask

    task automatic id_beq(input logic [4:0] s, input logic [4:0] t, input logic eq);
        set_id(0, 0, 0, 0, 0, 0, 1, 0, 2'b11, s, t, 5'd0, eq);
    endtask

    task automatic id_j(input logic [4:0] s);
        set_id(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, s, 5'd0, 5'd0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_nop();
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_wreg} !== 12'd0)
            $display("FAIL reset_stage_outs: got %b want 0", {ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_wreg});
        else pass_cnt++;
        total_cnt++;
        if ({fwd_a, fwd_b, stall, flush} !== 6'd0)
            $display("FAIL reset_comb_outs: got %b want 0", {fwd_a, fwd_b, stall, flush});
        else pass_cnt++;
    endtask

    task automatic test_latency();
        do_reset();
        id_lw(5'd9, 5'd1);
        step();
        id_nop();
        total_cnt++;
        if ({ex_alu_src, ex_alu_op} !== 3'b100) $display("FAIL lat_ex: got %b want 100", {ex_alu_src, ex_alu_op});
        else pass_cnt++;
        step();
        total_cnt++;
        if (mem_mem_read !== 1'b1) $display("FAIL lat_mem: got %b want 1", mem_mem_read);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wb_reg_write, wb_mem_to_reg, wb_wreg} !== {1'b1, 1'b1, 5'd9})
            $display("FAIL lat_wb: got %b want 1101001", {wb_reg_write, wb_mem_to_reg, wb_wreg});
        else pass_cnt++;
    endtask

    task automatic test_normalise();
        do_reset();
        // store-like: no register write, RegDst/MemtoReg asserted spuriously
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b00, 5'd1, 5'd2, 5'd7, 0);
        step();
        id_nop();
        step();
        total_cnt++;
        if (mem_mem_write !== 1'b1) $display("FAIL norm_memwrite: got %b want 1", mem_mem_write);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wb_reg_write, wb_mem_to_reg, wb_wreg} !== 7'd0)
            $display("FAIL norm_wb: got %b want 0", {wb_reg_write, wb_mem_to_reg, wb_wreg});
        else pass_cnt++;
    endtask

    task automatic test_fwd_mem();
        do_reset();
        id_rtype(5'd3, 5'd1, 5'd2);
        step();
        id_rtype(5'd4, 5'd3, 5'd5);
        step();
        id_nop();
        total_cnt++;
        if (fwd_a !== 2'b10) $display("FAIL fwd_mem_a: got %b want 10", fwd_a);
        else pass_cnt++;
        total_cnt++;
        if (fwd_b !== 2'b00) $display("FAIL fwd_mem_b: got %b want 00", fwd_b);
        else pass_cnt++;
    endtask

    task automatic test_fwd_wb();
        do_reset();
        id_rtype(5'd3, 5'd1, 5'd2);
        step();
        id_rtype(5'd6, 5'd7, 5'd8);
        step();
        id_rtype(5'd4, 5'd5, 5'd3);
        step();
        id_nop();
        total_cnt++;
        if (fwd_b !== 2'b01) $display("FAIL fwd_wb_b: got %b want 01", fwd_b);
        else pass_cnt++;
        total_cnt++;
        if (fwd_a !== 2'b00) $display("FAIL fwd_wb_a: got %b want 00", fwd_a);
        else pass_cnt++;
    endtask

    task automatic test_fwd_priority();
        do_reset();
        id_rtype(5'd3, 5'd1, 5'd2);
        step();
        id_rtype(5'd3, 5'd4, 5'd5);
        step();
        id_rtype(5'd6, 5'd3, 5'd3);
        step();
        id_nop();
        total_cnt++;
        if ({fwd_a, fwd_b} !== 4'b1010) $display("FAIL fwd_priority: got %b want 1010", {fwd_a, fwd_b});
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        id_lw(5'd2, 5'd1);
        step();
        id_rtype(5'd4, 5'd2, 5'd3);
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({stall, ex_alu_op} !== 3'b000) $display("FAIL lu_bubble: got %b want 000", {stall, ex_alu_op});
        else pass_cnt++;
        step();
        id_nop();
        total_cnt++;
        if (mem_mem_read !== 1'b0) $display("FAIL lu_mem_bubble: got %b want 0", mem_mem_read);
        else pass_cnt++;
        total_cnt++;
        if (fwd_a !== 2'b01) $display("FAIL lu_fwd_a: got %b want 01", fwd_a);
        else pass_cnt++;
        total_cnt++;
        if (ex_alu_op !== 2'b10) $display("FAIL lu_ex_add: got %b want 10", ex_alu_op);
        else pass_cnt++;
    endtask

    task automatic test_branch_after_load();
        do_reset();
        id_lw(5'd2, 5'd1);
        step();
        id_beq(5'd2, 5'd3, 1'b1);
        total_cnt++;
        if ({stall, flush} !== 2'b10) $display("FAIL bl_cyc1: got %b want 10", {stall, flush});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({stall, flush} !== 2'b10) $display("FAIL bl_cyc2: got %b want 10", {stall, flush});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({stall, flush} !== 2'b01) $display("FAIL bl_cyc3_taken: got %b want 01", {stall, flush});
        else pass_cnt++;
        br_eq = 1'b0;
        #1;
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL bl_cyc3_not_taken: got %b want 0", flush);
        else pass_cnt++;
    endtask

    task automatic test_branch_after_alu();
        do_reset();
        id_rtype(5'd2, 5'd1, 5'd4);
        step();
        id_beq(5'd3, 5'd2, 1'b1);
        total_cnt++;
        if ({stall, flush} !== 2'b10) $display("FAIL ba_cyc1: got %b want 10", {stall, flush});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({stall, flush} !== 2'b01) $display("FAIL ba_cyc2: got %b want 01", {stall, flush});
        else pass_cnt++;
    endtask

    task automatic test_jump();
        do_reset();
        id_j(5'd0);
        total_cnt++;
        if ({stall, flush} !== 2'b01) $display("FAIL j_free: got %b want 01", {stall, flush});
        else pass_cnt++;
        id_lw(5'd2, 5'd1);
        step();
        id_j(5'd2);
        total_cnt++;
        if ({stall, flush} !== 2'b10) $display("FAIL j_stalled: got %b want 10", {stall, flush});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({stall, flush} !== 2'b01) $display("FAIL j_after_stall: got %b want 01", {stall, flush});
        else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        do_reset();
        id_rtype(5'd0, 5'd1, 5'd2);
        step();
        id_rtype(5'd4, 5'd0, 5'd5);
        step();
        id_nop();
        total_cnt++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL zero_fwd: got %b want 0000", {fwd_a, fwd_b});
        else pass_cnt++;
        id_lw(5'd0, 5'd1);
        step();
        id_rtype(5'd4, 5'd0, 5'd3);
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL zero_no_stall: got %b want 0", stall);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        id_lw(5'd2, 5'd1);
        step();
        id_rtype(5'd5, 5'd6, 5'd7);
        step();
        total_cnt++;
        if ({mem_mem_read, ex_alu_op} !== 3'b110) $display("FAIL rst_pre: got %b want 110", {mem_mem_read, ex_alu_op});
        else pass_cnt++;
        rst = 1'b1;
        id_nop();
        step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_wreg,
             fwd_a, fwd_b, stall, flush} !== 18'd0)
            $display("FAIL rst_mid_outs: got %b want 0", {ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write,
                     wb_reg_write, wb_mem_to_reg, wb_wreg, fwd_a, fwd_b, stall, flush});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (wb_reg_write !== 1'b0) $display("FAIL rst_wb_quiet[%0d]: got %b want 0", i, wb_reg_write);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        id_nop();
        test_reset();
        test_latency();
        test_normalise();
        test_fwd_mem();
        test_fwd_wb();
        test_fwd_priority();
        test_load_use();
        test_branch_after_load();
        test_branch_after_alu();
        test_jump();
        test_zero_reg();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control carrier for the 5-stage MIPS core: takes the per-instruction control bundle produced by the ID-stage opcode decoder, registers it through the EX, MEM and WB stages, and returns the stage-local enables to the datapath. Detects load-use and branch-operand hazards (stall), control redirects (flush), and produces EX-stage forwarding selects. Sits between the decoder outputs and the ID/EX, EX/MEM and MEM/WB datapath registers.

## Interface
Parameters:
- REG_W, 5, register-number width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i, Branch_i, Jump_i  in  1 each  decoder bundle for the instruction in ID.
- ALUOp_i  in  2  decoder ALU class.
- rs_i, rt_i, rd_i  in  REG_W  register fields of the instruction in ID.
- br_eq_i  in  1  ID-stage comparator result (rs == rt).
- ex_ALUSrc_o  out  1;  ex_ALUOp_o  out  2.
- mem_MemRead_o, mem_MemWrite_o  out  1 each.
- wb_RegWrite_o, wb_MemtoReg_o  out  1 each;  wb_wreg_o  out  REG_W.
- fwd_a_o, fwd_b_o  out  2  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- stall_o  out  1  hold PC and IF/ID.
- flush_o  out  1  zero IF/ID (redirect taken).

## Operation
- Normalisation in ID: if RegWrite_i=0, RegDst and MemtoReg are treated as 0; X on unused decoder fields never reaches stage registers. id_wreg = RegDst ? rd_i : rt_i, forced to 0 when RegWrite_i=0.
- Stage registers: EX {ALUSrc, ALUOp, RegWrite, MemtoReg, MemRead, MemWrite, rs, rt, wreg}; MEM {RegWrite, MemtoReg, MemRead, MemWrite, wreg}; WB {RegWrite, MemtoReg, wreg}. Each edge shifts ID->EX->MEM->WB.
- Load-use stall: ex.MemRead & ex.wreg!=0 & (ex.wreg==rs_i | ex.wreg==rt_i).
- Branch stall (Branch_i=1 only): (ex.RegWrite & ex.wreg!=0 & ex.wreg∈{rs_i,rt_i}) or (mem.MemRead & mem.wreg!=0 & mem.wreg∈{rs_i,rt_i}).
- stall_o = load-use | branch stall. While stalled, EX loads a bubble (all control 0, wreg 0); MEM/WB advance normally.
- flush_o = ~stall_o & (Jump_i | (Branch_i & br_eq_i)). Flushed instruction arrives as all-zero bundle next cycle; no extra action here.
- Forwarding (per operand, rs->A, rt->B): MEM match (mem.RegWrite, mem.wreg!=0, mem.wreg==ex.rs/rt) -> 10; else WB match -> 01; else 00. MEM priority over WB. $zero never forwarded.
- Unknown opcode: decoder drives RegWrite/MemRead/MemWrite/Branch/Jump as last values; block registers whatever is presented, normalised as above.

## Timing
- Reset: every stage register 0 on the first rising edge with rst_i=1; all outputs 0 (fwd 00, stall_o 0, flush_o 0). rst_i overrides stall and shift. Reset mid-operation discards all in-flight bundles in one edge.
- stall_o, flush_o, fwd_a_o, fwd_b_o: combinational from current stage registers and ID inputs, valid same cycle.
- Bundle latency: ID->ex_* 1 cycle, ->mem_* 2 cycles, ->wb_* 3 cycles.
- Load-use costs exactly 1 bubble; branch after ALU producer 1 bubble; branch after load 2 bubbles (EX then MEM hazard).
- Stall and Jump/taken branch in same cycle: stall wins, flush_o=0; redirect re-evaluated after stall clears.

## Structure
- Package ctrl_pkg: ctrl_bundle_t struct (fields above), FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01, ALUOp encodings (00 add, 10 R-type funct, 11 sub/compare).
- Sub-module fwd_unit: pure combinational forwarding select, instantiated twice (A, B). Hazard and stage registers stay in pipe_ctrl.

## Test plan
- R-type add $3=$1+$2 then sub $4=$3,$5 -> cycle of sub in EX: fwd_a_o=10; with one independent instruction between: fwd_a_o=01.
- lw $2,0($1) then add $4,$2,$3 -> stall_o=1 one cycle, EX bubble (mem_MemRead_o=0 two cycles later), then fwd_a_o=01.
- beq $2,$3 after lw $2 -> stall_o=1 two consecutive cycles, then flush_o=br_eq_i.
- j with stall_o=0 -> flush_o=1 same cycle; j while load-use stall active -> flush_o=0 that cycle, 1 next.
- Writes to $0 (add $0,$1,$2 then use $0) -> fwd 00, no stall.
- rst_i asserted with lw in MEM and add in EX -> after one edge all outputs 0, wb_RegWrite_o stays 0 for the next three cycles.
